// File: rtl/sample_queue.sv
// sample_queue: circular stereo sample store feeding a band FIR.
// Each new sample (once TAPS samples exist) triggers a replay of the most
// recent TAPS samples, oldest first, one per clock, framed by 'sequencing'.
module sample_queue #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int TAPS  = 1021
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               sequencing,
  output logic               overrun
);

  localparam int FW = $clog2(TAPS + 1);

  typedef enum logic {IDLE, SEQ} state_t;

  logic signed [15:0] mem_l [DEPTH];
  logic signed [15:0] mem_r [DEPTH];

  state_t             state_q;
  logic [AW-1:0]      new_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [FW-1:0]      fill_q;
  logic [FW-1:0]      fill_d;
  logic [FW-1:0]      cnt_q;
  logic               pending_q;
  logic               overrun_q;
  logic               seq_q;
  logic signed [15:0] lft_q;
  logic signed [15:0] rght_q;

  logic               start;
  logic               rd_en;
  logic [AW-1:0]      newest;
  logic [AW-1:0]      rd_start;

  // Next fill count, start condition and replay window base address
  always_comb begin
    fill_d   = (fill_q == FW'(TAPS)) ? fill_q : fill_q + FW'(1);
    start    = (state_q == IDLE) &&
               ((wrt_smpl && (fill_d == FW'(TAPS))) || pending_q);
    // A write in the start cycle is itself the newest sample; otherwise the
    // newest is the one just behind the write pointer.
    newest   = wrt_smpl ? new_ptr_q : new_ptr_q - AW'(1);
    rd_start = newest - AW'(TAPS - 1);
    rd_en    = (state_q == SEQ) && (cnt_q < FW'(TAPS));
  end

  // Sample storage writes; a write in a reset cycle is discarded
  always_ff @(posedge clk) begin
    if (wrt_smpl && !rst) begin
      mem_l[new_ptr_q] <= lft_smpl;
      mem_r[new_ptr_q] <= rght_smpl;
    end
  end

  // Registered RAM read ports, driven straight to the FIR data inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else if (rd_en) begin
      lft_q  <= mem_l[rd_ptr_q];
      rght_q <= mem_r[rd_ptr_q];
    end
  end

  // Write pointer, fill tracking and IDLE/SEQ replay sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      new_ptr_q <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      if (wrt_smpl) begin
        new_ptr_q <= new_ptr_q + AW'(1);
        fill_q    <= fill_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SEQ;
            seq_q     <= 1'b1;
            rd_ptr_q  <= rd_start;
            cnt_q     <= '0;
            pending_q <= 1'b0;
          end
        end
        SEQ: begin
          if (wrt_smpl) begin
            pending_q <= 1'b1;
            if (pending_q) overrun_q <= 1'b1;
          end
          // Reads issue in cycles 0..TAPS-1; cycle TAPS only presents the
          // last read data, then the window closes.
          if (cnt_q == FW'(TAPS)) begin
            state_q <= IDLE;
            seq_q   <= 1'b0;
          end else begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q    <= cnt_q + FW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
  assign sequencing = seq_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sample_queue.sv
// Directed bench for sample_queue with a reduced geometry (DEPTH=16, TAPS=13)
// so fill phase, pointer wrap, back-to-back replay, overrun and mid-sequence
// reset all fit in a short run.
module tb_sample_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TAPS  = 13;
  localparam int NVEC  = 18;

  logic               clk = 1'b0;
  logic               rst;
  logic               wrt_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
  logic               sequencing;
  logic               overrun;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [15:0] val;
    logic        exp_seq;
  } vec_t;

  vec_t tbl [NVEC];

  sample_queue #(.DEPTH(DEPTH), .AW(AW), .TAPS(TAPS)) dut (
    .clk(clk),
    .rst(rst),
    .wrt_smpl(wrt_smpl),
    .lft_smpl(lft_smpl),
    .rght_smpl(rght_smpl),
    .lft_out(lft_out),
    .rght_out(rght_out),
    .sequencing(sequencing),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rmap(input logic [15:0] v);
    return v ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one write strobe; returns on the negedge after the sampling edge.
  task automatic do_write(input logic [15:0] v);
    wrt_smpl  = 1'b1;
    lft_smpl  = v;
    rght_smpl = rmap(v);
    @(negedge clk);
    wrt_smpl  = 1'b0;
  endtask

  // Called at the negedge of sequence cycle 0; ends one cycle after the fall.
  task automatic expect_seq(input logic [15:0] newest);
    logic [15:0] e;
    chk("seq_rise", sequencing, 1'b1);
    for (int k = 1; k <= TAPS; k++) begin
      @(negedge clk);
      e = newest - 16'(TAPS) + 16'(k);
      chk("seq_high", sequencing, 1'b1);
      chk("lft_data", lft_out, e);
      chk("rght_data", rght_out, rmap(e));
    end
    @(negedge clk);
    chk("seq_fall", sequencing, 1'b0);
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_seq", sequencing, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].val     = 16'(i + 1);
      tbl[i].exp_seq = (i + 1) >= TAPS;
    end

    rst = 1'b1; wrt_smpl = 1'b0; lft_smpl = '0; rght_smpl = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_seq", sequencing, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_lft", lft_out, 16'd0);
    chk("rst_rght", rght_out, 16'd0);

    // Fill phase then steady replays; writes 17 and 18 wrap the pointer
    for (int i = 0; i < NVEC; i++) begin
      do_write(tbl[i].val);
      if (tbl[i].exp_seq) begin
        expect_seq(tbl[i].val);
        expect_idle(3);
      end else begin
        chk("fill_noseq", sequencing, 1'b0);
        expect_idle(20);
        chk("fill_lft", lft_out, 16'd0);
        chk("fill_rght", rght_out, 16'd0);
      end
    end
    chk("ovr_clean", overrun, 1'b0);

    // One write inside a sequence: back-to-back replay after 1 low cycle
    do_write(16'd19);
    fork
      expect_seq(16'd19);
      begin
        repeat (4) @(negedge clk);
        do_write(16'd20);
      end
    join
    @(negedge clk);
    expect_seq(16'd20);
    chk("single_pend_ovr", overrun, 1'b0);
    expect_idle(5);

    // Two writes inside one sequence: overrun sticks
    do_write(16'd21);
    fork
      expect_seq(16'd21);
      begin
        repeat (2) @(negedge clk);
        do_write(16'd22);
        repeat (3) @(negedge clk);
        do_write(16'd23);
      end
    join
    chk("ovr_set", overrun, 1'b1);
    @(negedge clk);
    expect_seq(16'd23);
    expect_idle(5);
    chk("ovr_sticky", overrun, 1'b1);

    // Reset at sequence cycle 5, with a write in the reset cycle
    do_write(16'd24);
    chk("pre_rst_seq", sequencing, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1; wrt_smpl = 1'b1; lft_smpl = 16'd777; rght_smpl = rmap(16'd777);
    @(negedge clk);
    rst = 1'b0; wrt_smpl = 1'b0;
    chk("midrst_seq", sequencing, 1'b0);
    chk("midrst_ovr", overrun, 1'b0);
    chk("midrst_lft", lft_out, 16'd0);
    chk("midrst_rght", rght_out, 16'd0);

    // Fill restarts: 12 writes give no sequence, the 13th starts one
    for (int v = 25; v <= 36; v++) begin
      do_write(16'(v));
      chk("refill_noseq", sequencing, 1'b0);
      expect_idle(20);
    end
    do_write(16'd37);
    expect_seq(16'd37);
    chk("final_ovr", overrun, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
